// File: rtl/core_pkg.sv
// Shared core definitions: writeback FSM states and load funct3 encodings.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_MEM   = 2'd1,
    WRITE_LOAD = 2'd2
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Selects the addressed byte/halfword of a memory word and extends it per load funct3.
module load_aligner
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = sext8(byte_sel);
      F3_LH:   result = sext16(half_sel);
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and one outstanding load onto the register file
// write port, with a one-entry load scoreboard driving the issue stall.
module writeback_unit
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            load_req_valid,
  output logic            load_req_ready,
  input  logic [4:0]      load_rd,
  input  logic [2:0]      load_funct3,
  input  logic [1:0]      load_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] regWriteData,
  output logic            reg_WE_L,
  output logic [2:0]      funct3,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard_stall
);

  wb_state_t state_q, state_d;

  logic            busy_q, busy_d;
  logic [4:0]      busy_rd_q, busy_rd_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_addr_q, ld_addr_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic            ld_pulse_q, ld_pulse_d;

  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_l_q, we_l_d;
  logic [2:0]      f3_q, f3_d;

  logic            load_issue;
  logic [XLEN-1:0] aligned;

  load_aligner u_load_aligner (
    .funct3  (ld_f3_q),
    .addr_lo (ld_addr_q),
    .rdata   (mem_rdata),
    .result  (aligned)
  );

  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_addr_d  = ld_addr_q;
    ld_data_d  = ld_data_q;
    load_issue = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_req_valid) begin
          ld_rd_d   = load_rd;
          ld_f3_d   = load_funct3;
          ld_addr_d = load_addr_lo;
          state_d   = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          ld_data_d = aligned;
          state_d   = WRITE_LOAD;
        end
      end
      WRITE_LOAD: begin
        // Any ALU cycle, even one targeting x0, holds the buffered load back.
        if (!alu_valid) begin
          load_issue = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy is released by the registered load pulse so the pulse cycle itself still stalls;
  // a new acceptance on that same edge re-arms the scoreboard.
  always_comb begin
    busy_d    = busy_q;
    busy_rd_d = busy_rd_q;
    if (ld_pulse_q) begin
      busy_d = 1'b0;
    end
    if (state_q == IDLE && load_req_valid) begin
      busy_d    = (load_rd != REG_X0);
      busy_rd_d = load_rd;
    end
  end

  always_comb begin
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    we_l_d     = 1'b1;
    ld_pulse_d = 1'b0;
    if (alu_valid) begin
      if (alu_rd != REG_X0) begin
        rd_d    = alu_rd;
        wdata_d = alu_result;
        f3_d    = F3_LW;
        we_l_d  = 1'b0;
      end
    end else if (load_issue && ld_rd_q != REG_X0) begin
      rd_d       = ld_rd_q;
      wdata_d    = ld_data_q;
      f3_d       = ld_f3_q;
      we_l_d     = 1'b0;
      ld_pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      busy_rd_q  <= '0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
      ld_pulse_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      we_l_q     <= 1'b1;
      f3_q       <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      busy_rd_q  <= busy_rd_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_addr_q  <= ld_addr_d;
      ld_data_q  <= ld_data_d;
      ld_pulse_q <= ld_pulse_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      we_l_q     <= we_l_d;
      f3_q       <= f3_d;
    end
  end

  assign load_req_ready = (state_q == IDLE);
  assign rd             = rd_q;
  assign regWriteData   = wdata_q;
  assign reg_WE_L       = we_l_q;
  assign funct3         = f3_q;

  assign hazard_stall = busy_q && (busy_rd_q != REG_X0) &&
                        ((rs1 == busy_rd_q) || (rs2 == busy_rd_q) ||
                         (alu_valid && (alu_rd == busy_rd_q)));

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a cycle-stamped scoreboard of expected writes.
module tb_writeback_unit;
  import core_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        load_req_valid;
  logic        load_req_ready;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd;
  logic [31:0] regWriteData;
  logic        reg_WE_L;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2;
  logic        hazard_stall;

  writeback_unit #(.XLEN(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_result     (alu_result),
    .load_req_valid (load_req_valid),
    .load_req_ready (load_req_ready),
    .load_rd        (load_rd),
    .load_funct3    (load_funct3),
    .load_addr_lo   (load_addr_lo),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .rd             (rd),
    .regWriteData   (regWriteData),
    .reg_WE_L       (reg_WE_L),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .hazard_stall   (hazard_stall)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  f3;
  } wr_t;

  wr_t sb[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int c, input logic [4:0] r, input logic [31:0] d, input logic [2:0] f);
    wr_t e;
    e.cyc  = c;
    e.rd   = r;
    e.data = d;
    e.f3   = f;
    sb.push_back(e);
  endtask

  // A write pulse is legal only in the exact cycle the scoreboard expects one.
  always @(negedge clock) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        wr_t e;
        e = sb.pop_front();
        chk("we_l_pulse", {31'd0, reg_WE_L}, 32'd0);
        chk("wr_rd", {27'd0, rd}, {27'd0, e.rd});
        chk("wr_data", regWriteData, e.data);
        chk("wr_funct3", {29'd0, funct3}, {29'd0, e.f3});
      end else begin
        chk("we_l_idle", {31'd0, reg_WE_L}, 32'd1);
      end
    end
  end

  task automatic do_load(input logic [4:0] r, input logic [2:0] f, input logic [1:0] a,
                         input logic [31:0] word, input logic [31:0] exp);
    load_req_valid = 1'b1;
    load_rd        = r;
    load_funct3    = f;
    load_addr_lo   = a;
    tick();
    load_req_valid = 1'b0;
    mem_rvalid     = 1'b1;
    mem_rdata      = word;
    push(cyc + 2, r, exp, f);
    tick();
    mem_rvalid = 1'b0;
    tick();
    tick();
  endtask

  logic [2:0]  t_f3   [10] = '{F3_LH, F3_LH, F3_LB, F3_LB, F3_LBU, F3_LBU, F3_LHU,
                               3'b011, 3'b110, F3_LW};
  logic [1:0]  t_addr [10] = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
  logic [31:0] t_word [10] = '{32'h0000_8001, 32'h7FFF_8001, 32'h1234_5678, 32'h0000_00F0,
                               32'h00A5_0000, 32'h80FF_1234, 32'h80FF_1234, 32'h1357_9BDF,
                               32'h2468_ACE0, 32'h89AB_CDEF};
  logic [31:0] t_exp  [10] = '{32'hFFFF_8001, 32'h0000_7FFF, 32'h0000_0056, 32'hFFFF_FFF0,
                               32'h0000_00A5, 32'h0000_0080, 32'h0000_1234, 32'h1357_9BDF,
                               32'h2468_ACE0, 32'h89AB_CDEF};

  initial begin
    int m;
    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    load_req_valid = 1'b0; load_rd = '0; load_funct3 = '0; load_addr_lo = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; rs1 = '0; rs2 = '0;
    repeat (3) tick();
    reset  = 1'b1;
    mon_en = 1'b1;

    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_data", regWriteData, 32'd0);
    chk("rst_we_l", {31'd0, reg_WE_L}, 32'd1);
    chk("rst_funct3", {29'd0, funct3}, 32'd0);
    chk("rst_ready", {31'd0, load_req_ready}, 32'd1);
    chk("rst_stall", {31'd0, hazard_stall}, 32'd0);

    // Single ALU write: one-cycle pulse in N+1
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
    push(cyc + 1, 5'd5, 32'hDEADBEEF, F3_LW);
    tick();
    alu_valid = 1'b0;
    chk("alu_we_n1", {31'd0, reg_WE_L}, 32'd0);
    chk("alu_data_n1", regWriteData, 32'hDEADBEEF);
    tick();
    chk("alu_we_n2", {31'd0, reg_WE_L}, 32'd1);

    // ALU write to x0 is dropped
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'h1234_5678;
    tick();
    alu_valid = 1'b0;
    chk("x0_alu_we", {31'd0, reg_WE_L}, 32'd1);
    tick();

    // LB at offset 3 with stall tracking on rs1
    load_req_valid = 1'b1; load_rd = 5'd7; load_funct3 = F3_LB; load_addr_lo = 2'd3;
    rs1 = 5'd7;
    chk("lb_ready_idle", {31'd0, load_req_ready}, 32'd1);
    chk("lb_stall_pre", {31'd0, hazard_stall}, 32'd0);
    tick();
    load_req_valid = 1'b0;
    chk("lb_ready_wait", {31'd0, load_req_ready}, 32'd0);
    chk("lb_stall_wait", {31'd0, hazard_stall}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    push(cyc + 2, 5'd7, 32'hFFFF_FF80, F3_LB);
    tick();
    mem_rvalid = 1'b0;
    chk("lb_stall_wl", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("lb_stall_pulse", {31'd0, hazard_stall}, 32'd1);
    chk("lb_ready_pulse", {31'd0, load_req_ready}, 32'd1);
    tick();
    chk("lb_stall_after", {31'd0, hazard_stall}, 32'd0);
    rs1 = 5'd0;

    // LHU at offset 2, accepted together with an ALU write
    load_req_valid = 1'b1; load_rd = 5'd9; load_funct3 = F3_LHU; load_addr_lo = 2'd2;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_result = 32'hAAAA_5555;
    push(cyc + 1, 5'd4, 32'hAAAA_5555, F3_LW);
    rs2 = 5'd9;
    tick();
    load_req_valid = 1'b0; alu_valid = 1'b0;
    chk("lhu_stall_rs2", {31'd0, hazard_stall}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    push(cyc + 2, 5'd9, 32'h0000_80FF, F3_LHU);
    tick();
    mem_rvalid = 1'b0;
    tick();
    tick();
    chk("lhu_stall_after", {31'd0, hazard_stall}, 32'd0);
    rs2 = 5'd0;

    // LW delayed by three ALU cycles in WRITE_LOAD
    load_req_valid = 1'b1; load_rd = 5'd12; load_funct3 = F3_LW; load_addr_lo = 2'd0;
    tick();
    load_req_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    m = cyc;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_valid  = 1'b1;
      alu_rd     = 5'(i + 1);
      alu_result = 32'(i + 1) * 32'h0101_0101;
      push(cyc + 1, 5'(i + 1), 32'(i + 1) * 32'h0101_0101, F3_LW);
      chk("lw_ready_held", {31'd0, load_req_ready}, 32'd0);
      tick();
    end
    alu_valid = 1'b0;
    chk("lw_ready_issue", {31'd0, load_req_ready}, 32'd0);
    push(m + 5, 5'd12, 32'hCAFE_F00D, F3_LW);
    tick();
    chk("lw_ready_back", {31'd0, load_req_ready}, 32'd1);
    tick();

    // Aligner coverage through the full load path
    for (int i = 0; i < 10; i++) begin
      do_load(5'(10 + i), t_f3[i], t_addr[i], t_word[i], t_exp[i]);
    end

    // Load to x0: no write, no scoreboard entry
    load_req_valid = 1'b1; load_rd = 5'd0; load_funct3 = F3_LW; load_addr_lo = 2'd0;
    tick();
    load_req_valid = 1'b0;
    chk("x0_ld_ready", {31'd0, load_req_ready}, 32'd0);
    chk("x0_ld_stall", {31'd0, hazard_stall}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rvalid = 1'b0;
    tick();
    tick();

    // Reset while waiting for memory discards the load
    load_req_valid = 1'b1; load_rd = 5'd7; load_funct3 = F3_LB; load_addr_lo = 2'd0;
    rs1 = 5'd7;
    tick();
    load_req_valid = 1'b0;
    chk("rst_mid_stall_pre", {31'd0, hazard_stall}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_mid_ready", {31'd0, load_req_ready}, 32'd1);
    chk("rst_mid_stall", {31'd0, hazard_stall}, 32'd0);
    chk("rst_mid_rd", {27'd0, rd}, 32'd0);
    chk("rst_mid_data", regWriteData, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("rst_mid_ready2", {31'd0, load_req_ready}, 32'd1);
    chk("rst_mid_stall2", {31'd0, hazard_stall}, 32'd0);
    repeat (3) tick();
    rs1 = 5'd0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of the RISC-V core, sitting between the execute/memory stages and the register file write port. Accepts single-cycle ALU results and one outstanding memory load, aligns and extends load data per `funct3`, and serialises both onto the register file's active-low write port. Also holds a one-entry load scoreboard and stalls issue when a source register is still awaiting load data.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  5  ALU destination register
- `alu_result`  in  32  ALU result
- `load_req_valid`  in  1  load issued this cycle
- `load_req_ready`  out  1  unit can accept a load; high only in IDLE
- `load_rd`  in  5  load destination register
- `load_funct3`  in  3  load type (LB/LH/LW/LBU/LHU)
- `load_addr_lo`  in  2  byte offset of the load address
- `mem_rvalid`  in  1  memory read data valid
- `mem_rdata`  in  32  raw aligned memory word
- `rd`  out  5  register file write index
- `regWriteData`  out  32  register file write data
- `reg_WE_L`  out  1  register file write enable, active-low
- `funct3`  out  3  funct3 of the current write; `3'b010` for ALU writes
- `rs1`, `rs2`  in  5 each  source registers of the instruction being issued
- `hazard_stall`  out  1  issue must hold this cycle

## Operation
- States: IDLE, WAIT_MEM, WRITE_LOAD.
- IDLE: `load_req_valid` captures `load_rd`, `load_funct3`, and `load_addr_lo`, sets busy, and moves to WAIT_MEM. `mem_rvalid` is ignored.
- WAIT_MEM: `mem_rvalid` captures formatted data into the load buffer and moves to WRITE_LOAD.
- WRITE_LOAD: in any cycle with `alu_valid` low, the load write is issued and the state returns to IDLE. ALU results always take priority over the buffered load.
- Load formatting: byte = `mem_rdata[8*addr_lo +: 8]`; halfword = `mem_rdata[16*addr_lo[1] +: 16]`.
  - 000 sign-extends the byte.
  - 001 sign-extends the halfword.
  - 100 zero-extends the byte.
  - 101 zero-extends the halfword.
  - 010 and all other codes pass the full word.
- Writes with destination x0 are dropped: `reg_WE_L` stays high, and no x0 load occupies the scoreboard.
- Scoreboard: `hazard_stall` = busy and `busy_rd` != 0 and (`rs1` == `busy_rd` or `rs2` == `busy_rd` or (`alu_valid` and `alu_rd` == `busy_rd`)). Upstream must not advance while stalled.
- Busy clears on the edge after the load write pulse, so a read in the pulse cycle is still stalled.
- A load issued in IDLE with `alu_valid` in the same cycle is legal: both proceed, and the ALU write occurs normally.

## Timing
- Reset values: `rd`=0, `regWriteData`=0, `reg_WE_L`=1, `funct3`=0, `load_req_ready`=1 (IDLE), `hazard_stall`=0, busy=0.
- Reset mid-operation discards any pending load and buffer contents.
- All write-port outputs are registered.
- `alu_valid` at cycle N produces `reg_WE_L`=0 during N+1 for exactly one cycle.
- `mem_rvalid` at cycle M produces the earliest load write pulse at M+2. Each cycle of `alu_valid` in WRITE_LOAD delays the pulse by one.
- `reg_WE_L` is never low for two sources in one cycle.
- Back-to-back ALU writes give consecutive pulses with no bubble.
- `load_req_ready` drops the cycle after acceptance. It returns high the cycle after the load write is issued.
- Throughput: one load per 3 cycles minimum.

## Structure
- Shared package `core_pkg`: `wb_state_t` enum (IDLE, WAIT_MEM, WRITE_LOAD) and funct3 load constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
- One sub-module `load_aligner`: purely combinational; inputs `funct3`, `addr_lo`, `rdata`; output 32-bit formatted word.
- FSM, buffer, scoreboard, and output registers live in `writeback_unit`.

## Test plan
- Reset, then ALU result `alu_rd`=5, `alu_result`=`32'hDEADBEEF` at N → `rd`=5, `regWriteData`=`32'hDEADBEEF`, `reg_WE_L`=0 during N+1 only.
- ALU with `alu_rd`=0 → `reg_WE_L` stays 1.
- LB, `addr_lo`=3, `mem_rdata`=`32'h80FF_1234`:
  - result `32'hFFFF_FF80` written to `load_rd`=7 at M+2.
  - `hazard_stall`=1 with `rs1`=7 from acceptance through the write cycle.
  - `hazard_stall`=0 the cycle after.
- LHU, `addr_lo`=2, same word → `32'h0000_80FF`.
- LW with `alu_valid` asserted for 3 cycles from M+1 → three ALU pulses, then the load pulse.
  - Never two writes in one cycle.
  - `load_req_ready` stays 0 until the load write is issued.
- Reset asserted in WAIT_MEM, then `mem_rvalid` pulse → no write, busy=0, `load_req_ready`=1, `hazard_stall`=0.
